restoring_divider: RTL

Sequential unsigned integer divider for WIDTH-bit operands, computing one quotient bit per clock by restoring trial subtraction. It is the subtract side of the arithmetic set built on the ripple-carry adder, for lab designs that need quotient and remainder without a combinational divider array. A start/busy/done handshake sequences each operation, and results stay registered until the next accepted start.

---
 rtl/restoring_divider.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/restoring_divider.sv
// restoring_divider
//   Sequential unsigned divider. It produces one quotient bit per clock by
//   restoring trial subtraction. A start/busy/done handshake sequences each
//   operation. Q, R and div_by_zero stay registered until the next accepted
//   operation completes.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears all state
//   start        request; accepted when busy = 0 (IDLE or DONE)
//   N, D         dividend / divisor, captured on the accepting edge
//   busy         high while iterating
//   done         one-cycle pulse when Q/R/div_by_zero are updated
//   Q, R         registered quotient / remainder
//   div_by_zero  set with done when the captured divisor was zero
module restoring_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_n;      // dividend shift register, MSB first
    logic [WIDTH-1:0]   r_d;      // captured divisor
    // The restored partial remainder is always < D, so it fits in WIDTH
    // bits; only the shifted/trial values need the extra bit.
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;    // working quotient
    logic [CNT_W-1:0]   r_cnt;    // iterations remaining
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_dbz;

    logic               w_accept;
    logic               w_d_zero;
    logic               w_last;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

    assign w_accept = start && (r_state != S_RUN);
    assign w_d_zero = (D == '0);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(1));

    // One restoring step: bring in the next dividend bit, try subtracting D,
    // keep the difference only if it did not go negative.
    assign w_rem_shift = {r_rem, r_n[WIDTH-1]};
    assign w_trial     = w_rem_shift - {1'b0, r_d};
    assign w_qbit      = ~w_trial[WIDTH];
    assign w_rem_next  = w_qbit ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_next = w_d_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n   <= '0;
            r_d   <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            if (w_d_zero) begin
                r_q   <= '1;
                r_r   <= N;
                r_dbz <= 1'b1;
            end else begin
                r_n   <= N;
                r_d   <= D;
                r_rem <= '0;
                r_quo <= '0;
                r_cnt <= CNT_W'(WIDTH);
            end
        end else if (r_state == S_RUN) begin
            r_n   <= r_n << 1;
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_q   <= w_quo_next;
                r_r   <= w_rem_next;
                r_dbz <= 1'b0;
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign Q           = r_q;
    assign R           = r_r;
    assign div_by_zero = r_dbz;

endmodule
